inv_sqrt_stream_checker: RTL and testbench
==========================================

// Module: inv_sqrt_stream_checker
// PURPOSE
//   Synthesizable self-checker for the inverse-square-root datapath: buffers golden (C-model) results
//   in a FIFO, compares each DUT result (DataOut/DataValid) against the next golden word with a
//   parametrised tolerance, and keeps sample/error counters plus first-mismatch capture.
//   Sits beside the inverse-square-root core on FPGA or in simulation; replaces file-based post-compare.
// PARAMETERS
//   DATA_W      32    width of golden and DUT words (unsigned compare)
//   TOL         2     max allowed |dut - exp|; a larger difference is a mismatch
//   FIFO_DEPTH  16    golden FIFO entries, power of two, >= 2
//   SAMPLES     1000  number of compares before done
//   CNT_W       16    width of sample/error counters and index (2^CNT_W > SAMPLES)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       synchronous, active-high reset
//   ce             in   1       clock enable; when low no push, no pop, no compare, state frozen
//   exp_valid      in   1       golden word offered
//   exp_ready      out  1       FIFO can accept (= !full && state != DONE)
//   exp_data       in   DATA_W  golden word
//   dut_valid      in   1       DUT result valid (DataValid); no backpressure to DUT
//   dut_data       in   DATA_W  DUT result (DataOut)
//   sample_cnt     out  CNT_W   compares completed
//   err_cnt        out  CNT_W   mismatches, saturates at all-ones
//   first_err_vld  out  1       sticky: a mismatch has been captured
//   first_err_idx  out  CNT_W   sample index (0-based) of first mismatch
//   first_err_exp  out  DATA_W  golden word of first mismatch
//   first_err_dut  out  DATA_W  DUT word of first mismatch
//   underflow      out  1       sticky: dut_valid while FIFO empty
//   done           out  1       SAMPLES compares completed
// BEHAVIOUR
//   - Reset: all outputs 0, FIFO pointers/count 0, state RUN; exp_ready goes 1 on the cycle after reset.
//   - Push: ce && exp_valid && exp_ready. FIFO registered, no bypass: a word pushed in cycle N is poppable from N+1.
//   - Pop/compare: ce && dut_valid && state==RUN && !empty -> pop head, register {exp, dut, idx}.
//   - Stage 2 (one cycle later): diff = (dut>exp)?dut-exp:exp-dut, DATA_W bits unsigned; sample_cnt+1;
//     if diff > TOL: err_cnt+1 (saturating); if !first_err_vld capture idx/exp/dut and set first_err_vld.
//   - Latency: dut_valid sampled in cycle N -> counters/capture updated at edge ending N+1.
//   - Empty: ce && dut_valid && empty in RUN -> underflow=1 (sticky), sample dropped, no count.
//   - Full: exp_ready=0; exp_valid held by source. Simultaneous push+pop when full is impossible; when
//     neither full nor empty, push and pop in the same cycle leave count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//   - FSM: RUN -> DONE when stage-2 update makes sample_cnt == SAMPLES; DONE holds until rst.
//     In DONE: exp_ready=0, dut_valid ignored (no underflow), all results frozen.
//   - ce low: pipeline stage 2 also stalls (pending compare completes on next ce-high edge).
//   - rst mid-operation: FIFO contents discarded, everything back to reset values next cycle.
// CONFIGURATION
//   CHK_MAXDIFF_EN defined: adds output max_diff [DATA_W] (reset 0), updated in stage 2 with
//     max(max_diff, diff) for every compare incl. passing ones; frozen in DONE.
//   Undefined: port and register absent; all other behaviour identical.
// TESTING
//   1. Push 4 golden 0x3F000000..03, DUT returns same 4 -> sample_cnt=4, err_cnt=0, first_err_vld=0.
//   2. exp 0x3F000010, dut 0x3F000012 (diff 2) then exp 0x3F000010, dut 0x3F00000D (diff 3)
//      -> err_cnt=1, first_err_idx=1, first_err_exp=0x3F000010, first_err_dut=0x3F00000D.
//   3. dut_valid with FIFO empty -> underflow=1, sample_cnt unchanged; fill 16 words -> exp_ready=0 on 16th.
//   4. ce toggled 60 cycles high / 60 low during a 1000-sample stream -> no push/pop while ce=0,
//      done=1 exactly when sample_cnt=1000, later dut_valid ignored.
//   5. rst asserted with 5 words queued and err_cnt=3 -> next cycle all outputs 0, FIFO empty.
//   6. CHK_MAXDIFF_EN: diffs 1,7,3 -> max_diff=7; build without macro compiles, ports match table.

Source files
------------

// File: rtl/inv_sqrt_stream_checker.sv
// ----------------------------------------------------------------------------
// inv_sqrt_stream_checker
//
// Purpose:
//   Self-checker for the inverse-square-root datapath. Golden words from the
//   C model are buffered in a FIFO. Each DUT result pops the next golden word.
//   One cycle later the two are compared with an absolute-difference
//   tolerance. The block keeps sample/error counters and captures the first
//   mismatch. After SAMPLES compares the block enters DONE and freezes.
//
// Optional feature (macro CHK_MAXDIFF_EN):
//   When defined, output max_diff holds the largest |dut - exp| seen over
//   all compares, including passing ones. When undefined, the port and its
//   register are absent.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   ce             in   clock enable; low freezes all state (FIFO, stage 2, FSM)
//   exp_valid      in   golden word offered
//   exp_ready      out  FIFO accepts a golden word (not full, not DONE)
//   exp_data       in   golden word
//   dut_valid      in   DUT result valid (the DUT sees no backpressure)
//   dut_data       in   DUT result
//   sample_cnt     out  compares completed
//   err_cnt        out  mismatches, saturating
//   first_err_vld  out  sticky: a first mismatch has been captured
//   first_err_idx  out  0-based sample index of the first mismatch
//   first_err_exp  out  golden word of the first mismatch
//   first_err_dut  out  DUT word of the first mismatch
//   underflow      out  sticky: dut_valid arrived while the FIFO was empty
//   done           out  SAMPLES compares completed
//   max_diff       out  (CHK_MAXDIFF_EN only) largest difference seen
//
// Handshake:
//   A golden word transfers on a rising edge where ce && exp_valid &&
//   exp_ready. The source keeps exp_valid and exp_data stable until the word
//   transfers. dut_valid is a one-cycle pulse per result and is never
//   stalled. A result that arrives while the FIFO is empty is dropped and
//   flagged through underflow.
// ----------------------------------------------------------------------------
module inv_sqrt_stream_checker #(
    parameter int DATA_W     = 32,
    parameter int TOL        = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLES    = 1000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              dut_valid,
    input  logic [DATA_W-1:0] dut_data,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              first_err_vld,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_dut,
    output logic              underflow,
    output logic              done
`ifdef CHK_MAXDIFF_EN
   ,output logic [DATA_W-1:0] max_diff
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]       CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
    localparam logic [CNT_W-1:0]  IDX_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SAMPLES - 1);
    localparam logic [DATA_W-1:0] TOL_C     = DATA_W'(TOL);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Golden FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty;

    // exp_ready is held low on the first cycle out of reset.
    logic              armed;

    logic              push, pop;
    logic [CNT_W-1:0]  pop_idx;     // index handed to the next popped sample

    // Stage-2 compare registers
    logic              s2_valid;
    logic [DATA_W-1:0] s2_exp, s2_dut;
    logic [CNT_W-1:0]  s2_idx;
    logic [DATA_W-1:0] diff;
    logic              s2_fire;
    logic              mismatch;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign exp_ready = armed && !full && (state_q == RUN);
    assign push      = ce && exp_valid && exp_ready;
    assign pop       = ce && dut_valid && (state_q == RUN) && !empty;

    assign diff      = (s2_dut > s2_exp) ? (s2_dut - s2_exp) : (s2_exp - s2_dut);
    assign mismatch  = (diff > TOL_C);
    // A compare that is pending when DONE is entered does not update the results.
    assign s2_fire   = ce && s2_valid && (state_q == RUN);

    // FIFO storage has no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            RUN: begin
                if (s2_fire && (sample_cnt == LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            armed         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pop_idx       <= '0;
            s2_valid      <= 1'b0;
            s2_exp        <= '0;
            s2_dut        <= '0;
            s2_idx        <= '0;
            sample_cnt    <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_dut <= '0;
            underflow     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (ce) begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    pop_idx <= pop_idx + IDX_ONE;
                    s2_exp  <= mem[rd_ptr];
                    s2_dut  <= dut_data;
                    s2_idx  <= pop_idx;
                end
                s2_valid <= pop;

                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase

                if (dut_valid && (state_q == RUN) && empty) begin
                    underflow <= 1'b1;
                end

                if (s2_fire) begin
                    sample_cnt <= sample_cnt + IDX_ONE;
                    if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + IDX_ONE;
                        end
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= s2_idx;
                            first_err_exp <= s2_exp;
                            first_err_dut <= s2_dut;
                        end
                    end
                end
            end
        end
    end

`ifdef CHK_MAXDIFF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            max_diff <= '0;
        end else if (s2_fire && (diff > max_diff)) begin
            max_diff <= diff;
        end
    end
`else
    // Without CHK_MAXDIFF_EN no max-difference tracking is built.
`endif

endmodule

// File: tb/tb_inv_sqrt_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_inv_sqrt_stream_checker
//
// Directed bench for inv_sqrt_stream_checker. It contains:
//   - a table of {golden, dut, is_err} vectors with hand-derived outcomes
//   - hand-written sequences for underflow, FIFO full, simultaneous
//     push/pop, stage-2 stall on ce, a 1000-sample stream with ce
//     toggling, mid-run reset, and (with CHK_MAXDIFF_EN) max_diff
// ----------------------------------------------------------------------------
module tb_inv_sqrt_stream_checker;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              ce = 1'b1;
    logic              exp_valid = 1'b0;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_data = '0;
    logic              dut_valid = 1'b0;
    logic [DATA_W-1:0] dut_data = '0;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              first_err_vld;
    logic [CNT_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_dut;
    logic              underflow;
    logic              done;
`ifdef CHK_MAXDIFF_EN
    logic [DATA_W-1:0] max_diff;
`endif

    inv_sqrt_stream_checker #(
        .DATA_W(32), .TOL(2), .FIFO_DEPTH(16), .SAMPLES(1000), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .dut_valid(dut_valid), .dut_data(dut_data),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_dut(first_err_dut),
        .underflow(underflow), .done(done)
`ifdef CHK_MAXDIFF_EN
       ,.max_diff(max_diff)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1; exp_valid = 1'b0; dut_valid = 1'b0;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        int t;
        t = 0;
        while (!exp_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t == 50) begin
            checks++; errors++;
            $display("FAIL push_timeout: exp_ready stuck at 0, required 1");
        end
        exp_valid = 1'b1;
        exp_data  = w;
        tick(1);
        exp_valid = 1'b0;
    endtask

    task automatic send_dut(input logic [DATA_W-1:0] w);
        dut_valid = 1'b1;
        dut_data  = w;
        tick(1);
        dut_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] d;
        bit                is_err;
    } vec_t;

    vec_t tbl[10];

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_exp;
        bit first_seen;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] fe_exp, fe_dut;
        int fe_idx;
        int pushed, popped, cyc, bad_freeze, bad_done;
        bit ce_v, push_ok, pop_ok;
        logic [CNT_W-1:0] prev;

        tbl[0] = '{32'h3F000000, 32'h3F000000, 1'b0};
        tbl[1] = '{32'h3F000001, 32'h3F000001, 1'b0};
        tbl[2] = '{32'h3F000002, 32'h3F000002, 1'b0};
        tbl[3] = '{32'h3F000003, 32'h3F000003, 1'b0};
        tbl[4] = '{32'h3F000010, 32'h3F000012, 1'b0}; // diff 2, inside tolerance
        tbl[5] = '{32'h3F000010, 32'h3F00000D, 1'b1}; // diff 3
        tbl[6] = '{32'h00000000, 32'hFFFFFFFF, 1'b1}; // maximum difference
        tbl[7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0}; // diff 1 at the top of the range
        tbl[8] = '{32'h00000005, 32'h00000003, 1'b0}; // exp > dut, diff 2
        tbl[9] = '{32'h00000003, 32'h00000006, 1'b1}; // diff 3

        // ---- reset values ----
        rst = 1'b1;
        tick(2);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_vld", first_err_vld, 0);
        check("rst_underflow", underflow, 0);
        check("rst_done", done, 0);
        check("rst_exp_ready", exp_ready, 0);
        rst = 1'b0;
        tick(1);
        check("exp_ready_after_rst", exp_ready, 1);

        // ---- table-driven compares ----
        err_exp = 0;
        first_seen = 0;
        fe_exp = '0; fe_dut = '0; fe_idx = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(tbl[i].e);
            exp_q.push_back(tbl[i].e);
            send_dut(tbl[i].d);
            tick(1);
            w = exp_q.pop_front();
            if (tbl[i].is_err) begin
                err_exp++;
                if (!first_seen) begin
                    first_seen = 1; fe_exp = w; fe_dut = tbl[i].d; fe_idx = i;
                end
            end
            check($sformatf("tbl%0d_sample_cnt", i), sample_cnt, i + 1);
            check($sformatf("tbl%0d_err_cnt", i), err_cnt, err_exp);
            if (i == 3) check("tbl3_first_vld", first_err_vld, 0);
        end
        check("tbl_first_vld", first_err_vld, 1);
        check("tbl_first_idx", first_err_idx, fe_idx);
        check("tbl_first_exp", first_err_exp, fe_exp);
        check("tbl_first_dut", first_err_dut, fe_dut);
        check("tbl_first_dut_const", first_err_dut, 32'h3F00000D);

        // ---- two queued words, tolerance boundary, first-mismatch index ----
        do_reset();
        push_word(32'h3F000010);
        push_word(32'h3F000010);
        send_dut(32'h3F000012);
        send_dut(32'h3F00000D);
        tick(1);
        check("t2_sample_cnt", sample_cnt, 2);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_first_vld", first_err_vld, 1);
        check("t2_first_idx", first_err_idx, 1);
        check("t2_first_exp", first_err_exp, 32'h3F000010);
        check("t2_first_dut", first_err_dut, 32'h3F00000D);

        // ---- simultaneous push and pop; count must return to empty ----
        do_reset();
        push_word(32'hA);
        exp_valid = 1'b1; exp_data = 32'hB;
        dut_valid = 1'b1; dut_data = 32'hA;
        tick(1);
        exp_valid = 1'b0;
        dut_data  = 32'hB;
        tick(1);
        dut_valid = 1'b0;
        tick(1);
        check("pp_sample_cnt", sample_cnt, 2);
        check("pp_err_cnt", err_cnt, 0);
        check("pp_no_underflow", underflow, 0);
        send_dut(32'h0);
        check("pp_empty_underflow", underflow, 1);

        // ---- stage 2 stalls while ce is low ----
        do_reset();
        push_word(32'h100);
        send_dut(32'h105);
        ce = 1'b0;
        tick(3);
        check("stall_sample_cnt", sample_cnt, 0);
        check("stall_err_cnt", err_cnt, 0);
        ce = 1'b1;
        tick(1);
        check("stall_release_sample_cnt", sample_cnt, 1);
        check("stall_release_err_cnt", err_cnt, 1);
        check("stall_first_idx", first_err_idx, 0);
        check("stall_first_dut", first_err_dut, 32'h105);

        // ---- underflow, then fill the FIFO to full ----
        do_reset();
        send_dut(32'h55);
        check("uf_underflow", underflow, 1);
        tick(1);
        check("uf_sample_cnt", sample_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            push_word(32'h200 + i);
            if (i == 14) check("fill15_exp_ready", exp_ready, 1);
            if (i == 15) check("fill16_exp_ready", exp_ready, 0);
        end
        // A word offered while full must not enter the FIFO.
        exp_valid = 1'b1; exp_data = 32'hDEAD;
        tick(3);
        exp_valid = 1'b0;
        for (int i = 0; i < 16; i++) send_dut(32'h200 + i);
        tick(1);
        check("drain_sample_cnt", sample_cnt, 16);
        check("drain_err_cnt", err_cnt, 0);
        send_dut(32'hDEAD);
        tick(1);
        check("drain_empty_sample_cnt", sample_cnt, 16);

        // ---- 1000-sample stream with ce 60 cycles high / 60 low ----
        // Samples with idx % 100 == 50 carry dut = exp + 3: 10 mismatches, first at 50.
        do_reset();
        pushed = 0; popped = 0; cyc = 0; bad_freeze = 0; bad_done = 0;
        while (popped < 1000 && cyc < 6000) begin
            ce_v = ((cyc / 60) % 2) == 0;
            ce = ce_v;
            exp_valid = (pushed < 1000);
            exp_data  = DATA_W'(pushed);
            if (ce_v && popped < pushed) begin
                dut_valid = 1'b1;
                dut_data  = (popped % 100 == 50) ? DATA_W'(popped + 3) : DATA_W'(popped);
            end else if (!ce_v) begin
                dut_valid = 1'b1;             // ignored while ce is low
                dut_data  = '1;
            end else begin
                dut_valid = 1'b0;
            end
            push_ok = ce_v && exp_valid && exp_ready;
            pop_ok  = ce_v && dut_valid;
            prev    = sample_cnt;
            tick(1);
            cyc++;
            if (push_ok) pushed++;
            if (pop_ok) popped++;
            if (!ce_v && sample_cnt != prev) bad_freeze++;
            if (done != (sample_cnt == 16'd1000)) bad_done++;
        end
        ce = 1'b1; exp_valid = 1'b0; dut_valid = 1'b0;
        tick(2);
        check("stream_all_popped", popped, 1000);
        check("stream_freeze_violations", bad_freeze, 0);
        check("stream_done_violations", bad_done, 0);
        check("stream_sample_cnt", sample_cnt, 1000);
        check("stream_err_cnt", err_cnt, 10);
        check("stream_first_idx", first_err_idx, 50);
        check("stream_first_exp", first_err_exp, 50);
        check("stream_first_dut", first_err_dut, 53);
        check("stream_done", done, 1);
        check("stream_done_exp_ready", exp_ready, 0);
        check("stream_no_underflow", underflow, 0);
        send_dut(32'h7);
        tick(1);
        check("done_ignores_sample_cnt", sample_cnt, 1000);
        check("done_ignores_underflow", underflow, 0);
        check("done_holds", done, 1);

        // ---- reset mid-run with 5 words queued and err_cnt = 3 ----
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'h0);
        for (int i = 0; i < 3; i++) send_dut(32'h9);
        tick(1);
        check("pre_rst_err_cnt", err_cnt, 3);
        for (int i = 0; i < 5; i++) push_word(32'h1000 + i);
        rst = 1'b1;
        tick(1);
        check("mid_rst_sample_cnt", sample_cnt, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_first_vld", first_err_vld, 0);
        check("mid_rst_first_idx", first_err_idx, 0);
        check("mid_rst_first_exp", first_err_exp, 0);
        check("mid_rst_first_dut", first_err_dut, 0);
        check("mid_rst_underflow", underflow, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_exp_ready", exp_ready, 0);
        rst = 1'b0;
        tick(1);
        send_dut(32'h1000);
        check("post_rst_fifo_empty", underflow, 1);
        tick(1);
        check("post_rst_sample_cnt", sample_cnt, 0);

`ifdef CHK_MAXDIFF_EN
        // ---- max_diff over diffs 1, 7, 3 ----
        do_reset();
        check("maxdiff_rst", max_diff, 0);
        for (int i = 0; i < 3; i++) push_word(32'h10);
        send_dut(32'h11);
        send_dut(32'h17);
        send_dut(32'h0D);
        tick(1);
        check("maxdiff_value", max_diff, 7);
        check("maxdiff_err_cnt", err_cnt, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
